// File: rtl/bp_pkg.sv
// Branch-predictor constants and the per-branch metadata record shared by
// the perceptron predictor, the in-flight queue and the trainer.
package bp_pkg;
    localparam int HISTORY_SIZE = 62;
    localparam int IDX_W        = 10;
    localparam int SUM_W        = 16;
    localparam int THETA        = 133;

    typedef struct packed {
        logic [IDX_W-1:0]        idx;
        logic signed [SUM_W-1:0] sum;
        logic                    pred;
        logic [HISTORY_SIZE-1:0] history;
    } bp_meta_t;

    // Widened by one bit so the magnitude of the most negative sum fits.
    function automatic logic [SUM_W:0] abs_sum(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W:0] ext;
        ext = {s[SUM_W-1], s};
        return ext[SUM_W] ? -ext : ext;
    endfunction
endpackage

// File: rtl/inflight_fifo.sv
// Generic circular buffer with wrap-bit pointers and a flush that discards
// every entry younger than the one being read.
module inflight_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    input  logic                   flush,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  head_q, head_d, tail_q, tail_d;
    logic [W-1:0] mem_q [DEPTH];

    assign count   = tail_q - head_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem_q[head_q[AW-1:0]];

    // Flush pulls the tail back onto the post-read head, so occupancy becomes 0.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (rd_en && !empty) head_d = head_q + (AW+1)'(1);
        if (flush)                   tail_d = head_d;
        else if (wr_en && !full)     tail_d = tail_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full && !flush) mem_q[tail_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/perceptron_inflight_queue.sv
// Tracks perceptron predictions until resolution, owns the speculative global
// history and issues training requests. BP_INFLIGHT_STATS_EN adds 32-bit counters.
module perceptron_inflight_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [IDX_W-1:0]        push_idx,
    input  logic [SUM_W-1:0]        push_sum,
    input  logic                    push_pred,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    output logic [HISTORY_SIZE-1:0] spec_history,
    output logic                    train_valid,
    output logic [IDX_W-1:0]        train_idx,
    output logic [HISTORY_SIZE-1:0] train_history,
    output logic                    train_taken,
    output logic                    mispredict,
    output logic [$clog2(DEPTH):0]  count,
`ifdef BP_INFLIGHT_STATS_EN
    output logic [31:0]             stat_resolved,
    output logic [31:0]             stat_mispred,
    output logic [31:0]             stat_trained,
`endif
    output logic                    underflow_err
);
    bp_meta_t head, wr_meta;
    logic     fifo_full, fifo_empty, pop, mispred_now, train_now, push_acc;

    logic [HISTORY_SIZE-1:0] spec_history_q, spec_history_d;
    logic                    train_valid_q, train_taken_q, mispredict_q, underflow_q;
    logic [IDX_W-1:0]        train_idx_q;
    logic [HISTORY_SIZE-1:0] train_history_q;

    assign push_ready  = !fifo_full;
    assign pop         = resolve_valid && !fifo_empty;
    assign mispred_now = pop && (resolve_taken != head.pred);
    assign train_now   = pop && (mispred_now || (abs_sum(head.sum) <= (SUM_W+1)'(THETA)));
    // A push in the same cycle as a mispredict is on the wrong path.
    assign push_acc    = push_valid && !fifo_full && !mispred_now;
    assign wr_meta     = '{idx: push_idx, sum: push_sum, pred: push_pred, history: spec_history_q};

    inflight_fifo #(.DEPTH(DEPTH), .W($bits(bp_meta_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_acc),
        .wr_data (wr_meta),
        .rd_en   (pop),
        .flush   (mispred_now),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        spec_history_d = spec_history_q;
        if (mispred_now)
            spec_history_d = {head.history[HISTORY_SIZE-2:0], resolve_taken};
        else if (push_acc)
            spec_history_d = {spec_history_q[HISTORY_SIZE-2:0], push_pred};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_history_q  <= '0;
            train_valid_q   <= 1'b0;
            train_idx_q     <= '0;
            train_history_q <= '0;
            train_taken_q   <= 1'b0;
            mispredict_q    <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            spec_history_q <= spec_history_d;
            train_valid_q  <= train_now;
            mispredict_q   <= mispred_now;
            underflow_q    <= underflow_q | (resolve_valid && fifo_empty);
            if (pop) begin
                train_idx_q     <= head.idx;
                train_history_q <= head.history;
                train_taken_q   <= resolve_taken;
            end
        end
    end

    assign spec_history  = spec_history_q;
    assign train_valid   = train_valid_q;
    assign train_idx     = train_idx_q;
    assign train_history = train_history_q;
    assign train_taken   = train_taken_q;
    assign mispredict    = mispredict_q;
    assign underflow_err = underflow_q;

`ifdef BP_INFLIGHT_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q, stat_trained_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
            stat_trained_q  <= '0;
        end else begin
            if (pop && (stat_resolved_q != '1))        stat_resolved_q <= stat_resolved_q + 32'd1;
            if (mispred_now && (stat_mispred_q != '1)) stat_mispred_q  <= stat_mispred_q + 32'd1;
            if (train_now && (stat_trained_q != '1))   stat_trained_q  <= stat_trained_q + 32'd1;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
    assign stat_trained  = stat_trained_q;
`endif
endmodule

// File: tb/tb_perceptron_inflight_queue.sv
// Directed bench for perceptron_inflight_queue: stimulus tasks push expected
// training responses into exp_q and a monitor pops them as results appear.
module tb_perceptron_inflight_queue;
    import bp_pkg::*;

    localparam int DEPTH = 8;
    localparam int EW    = 2 + IDX_W + HISTORY_SIZE + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    push_valid, push_ready, push_pred;
    logic [IDX_W-1:0]        push_idx;
    logic [SUM_W-1:0]        push_sum;
    logic                    resolve_valid, resolve_taken;
    logic [HISTORY_SIZE-1:0] spec_history, train_history;
    logic                    train_valid, train_taken, mispredict, underflow_err;
    logic [IDX_W-1:0]        train_idx;
    logic [$clog2(DEPTH):0]  count;
`ifdef BP_INFLIGHT_STATS_EN
    logic [31:0]             stat_resolved, stat_mispred, stat_trained;
`endif

    perceptron_inflight_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_idx      (push_idx),
        .push_sum      (push_sum),
        .push_pred     (push_pred),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .spec_history  (spec_history),
        .train_valid   (train_valid),
        .train_idx     (train_idx),
        .train_history (train_history),
        .train_taken   (train_taken),
        .mispredict    (mispredict),
        .count         (count),
`ifdef BP_INFLIGHT_STATS_EN
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred),
        .stat_trained  (stat_trained),
`endif
        .underflow_err (underflow_err)
    );

    // Clock / reset
    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0]        idx;
        logic [SUM_W-1:0]        sum;
        logic                    pred;
        logic [HISTORY_SIZE-1:0] hist;
    } ent_t;

    ent_t                    mq[$];
    logic [HISTORY_SIZE-1:0] m_hist;
    logic                    m_uf;
    logic [EW-1:0]           exp_q[$];
    int                      n_checks = 0;
    int                      n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: checks queue state against the model, then applies one cycle of inputs.
    task automatic drive(input logic pv, input int idx, input int sum, input logic pred,
                         input logic rv, input logic rt);
        ent_t h;
        logic full, pop, mis, tv;
        int   s;
        @(negedge clk);
        check("count", count, mq.size());
        check("push_ready", push_ready, mq.size() < DEPTH);
        check("spec_history", spec_history, m_hist);
        check("underflow_err", underflow_err, m_uf);
        push_valid    = pv;
        push_idx      = idx[IDX_W-1:0];
        push_sum      = sum[SUM_W-1:0];
        push_pred     = pred;
        resolve_valid = rv;
        resolve_taken = rt;
        full = (mq.size() == DEPTH);
        pop  = rv && (mq.size() != 0);
        mis  = 1'b0;
        if (rv && !pop) begin
            m_uf = 1'b1;
            exp_q.push_back('0);
        end
        if (pop) begin
            h   = mq.pop_front();
            mis = (rt != h.pred);
            s   = int'($signed(h.sum));
            if (s < 0) s = -s;
            tv  = mis || (s <= THETA);
            exp_q.push_back({tv, mis, h.idx, h.hist, rt});
        end
        if (mis) begin
            mq.delete();
            m_hist = {h.hist[HISTORY_SIZE-2:0], rt};
        end else if (pv && !full) begin
            mq.push_back('{idx: idx[IDX_W-1:0], sum: sum[SUM_W-1:0], pred: pred, hist: m_hist});
            m_hist = {m_hist[HISTORY_SIZE-2:0], pred};
        end
    endtask

    task automatic step();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: one expected record per resolve seen at a clock edge.
    initial begin
        logic          pend;
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            pend = resolve_valid && !rst;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_nonempty", 1'b0, 1'b1);
                end else begin
                    e = exp_q.pop_front();
                    check("train_valid", train_valid, e[EW-1]);
                    check("mispredict", mispredict, e[EW-2]);
                    if (e[EW-1]) begin
                        check("train_idx", train_idx, e[HISTORY_SIZE+IDX_W:HISTORY_SIZE+1]);
                        check("train_history", train_history, e[HISTORY_SIZE:1]);
                        check("train_taken", train_taken, e[0]);
                    end
                end
            end else begin
                check("idle_pulse", {train_valid, mispredict}, 2'b00);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    int fill_sums [DEPTH] = '{133, 134, -133, -134, -32768, 32767, 0, -1};

    initial begin
        rst = 1'b1;
        push_valid = 0; push_idx = '0; push_sum = '0; push_pred = 0;
        resolve_valid = 0; resolve_taken = 0;
        m_hist = '0; m_uf = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_spec_history", spec_history, 0);
        check("rst_train_valid", train_valid, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_underflow", underflow_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Three pushes from zero history.
        drive(1, 1, 50, 1, 0, 0);
        drive(1, 2, 50, 0, 0, 0);
        drive(1, 3, 50, 1, 0, 0);
        step();
        check("hist_101", spec_history[2:0], 3'b101);
        check("count_3", count, 3);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 0);
        step();
        check("entry1_snapshot", train_history, 62'd1);
        drive(0, 0, 0, 0, 1, 1);

        // Confident correct prediction: no training.
        drive(1, 5, 200, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        step();
        check("conf_train_valid", train_valid, 1'b0);
        check("conf_mispredict", mispredict, 1'b0);

        // Low-confidence correct prediction: training.
        drive(1, 7, -40, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        step();
        check("low_train_valid", train_valid, 1'b1);
        check("low_train_idx", train_idx, 7);
        check("low_train_taken", train_taken, 1'b0);

        // Mispredict with concurrent push: flush and history repair.
        for (int i = 0; i < 4; i++) drive(1, 20 + i, 10, 1, 0, 0);
        drive(1, 30, 10, 1, 1, 0);
        step();
        check("mis_count", count, 0);
        check("mis_pulse", mispredict, 1'b1);
        check("mis_repair", spec_history, 62'h2C);

        // Fill, overflow attempt, then drain across the wrap with interleaved pushes.
        for (int i = 0; i < DEPTH; i++) drive(1, 40 + i, fill_sums[i], i[0], 0, 0);
        drive(1, 99, 0, 1, 0, 0);
        step();
        check("full_ready", push_ready, 1'b0);
        check("full_count", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(1, 60 + i, 5, i[0], 1, mq[0].pred);
        for (int i = 0; i < DEPTH - 1; i++) drive(0, 0, 0, 0, 1, mq[0].pred);
        step();
        check("drained_count", count, 0);

        // Resolve on empty is sticky until reset.
        drive(0, 0, 0, 0, 1, 1);
        step();
        check("underflow_set", underflow_err, 1'b1);
        step();
        step();
        check("underflow_held", underflow_err, 1'b1);

        // Asynchronous reset mid-queue.
        drive(1, 11, 7, 1, 0, 0);
        drive(1, 12, 7, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_ready", push_ready, 1'b1);
        check("arst_spec_history", spec_history, 0);
        check("arst_underflow", underflow_err, 0);
        check("arst_train_valid", train_valid, 0);
        check("arst_train_idx", train_idx, 0);
        check("arst_train_history", train_history, 0);
        check("arst_train_taken", train_taken, 0);
        check("arst_mispredict", mispredict, 0);
        mq.delete();
        m_hist = '0;
        m_uf   = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        drive(1, 9, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        step();
        step();
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/perceptron_inflight_queue.md
Name: perceptron_inflight_queue

Overview:
- Sits between the decode-stage perceptron predictor and the execute-stage branch feedback.
- Holds per-branch prediction metadata from predict time until resolution. Metadata: perceptron index, history snapshot, dot-product sum, predicted direction.
- Maintains the speculative global history used for prediction, and repairs it on mispredict.
- Emits one registered training request per resolved branch to the perceptron trainer.

Parameters:
- DEPTH, 8, in-flight entries (power of two, >=2)
- HISTORY_SIZE, 62, global history bits
- IDX_W, 10, perceptron index width (log2 of 1024 perceptrons)
- SUM_W, 16, signed width of the perceptron output sum
- THETA, 133, training threshold, floor(1.93*HISTORY_SIZE+14)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- push_valid  in  1  decode has a predicted conditional branch
- push_ready  out  1  queue can accept (not full)
- push_idx  in  IDX_W  selected perceptron
- push_sum  in  SUM_W  signed perceptron output
- push_pred  in  1  predicted taken
- resolve_valid  in  1  execute resolved the oldest in-flight branch
- resolve_taken  in  1  actual direction
- spec_history  out  HISTORY_SIZE  speculative global history for the predictor
- train_valid  out  1  training request valid
- train_idx  out  IDX_W  perceptron to train
- train_history  out  HISTORY_SIZE  history snapshot used at predict time
- train_taken  out  1  actual direction
- mispredict  out  1  pulse: resolved branch mispredicted
- count  out  $clog2(DEPTH)+1  occupancy
- underflow_err  out  1  sticky: resolve arrived with queue empty

Behaviour:
- Reset (async, rst=1): all of the following clear to 0.
  - Head/tail pointers, count, spec_history, underflow_err.
  - train_valid, train_idx, train_history, train_taken, mispredict.
- Clearing on reset is immediate and overrides any in-flight push or resolve.
- Storage: circular buffer, DEPTH entries. Each entry holds {idx, sum, pred, history snapshot = spec_history value before this push}.
- Pointers carry an extra wrap bit. full = (count==DEPTH); empty = (count==0).
- push_ready = !full (combinational).
- Push accepted when push_valid && push_ready.
  - Entry written at tail.
  - spec_history <= {spec_history[HISTORY_SIZE-2:0], push_pred}.
- push_valid with full: no write, no history change.
- Resolve pops the head in order. Then, registered with 1-cycle latency:
  - train_valid = 1 iff (resolve_taken != head.pred) || (|head.sum| <= THETA).
  - |sum| is computed in SUM_W+1 bits so that the most negative value does not overflow.
  - train_idx, train_history, train_taken come from the head entry and resolve_taken.
  - mispredict = (resolve_taken != head.pred).
  - train_valid and mispredict are otherwise 0 (single-cycle pulses).
- Mispredict recovery, same edge as the pop:
  - All younger entries are flushed: tail <= head+1, count <= 0.
  - spec_history <= {head.history[HISTORY_SIZE-2:0], resolve_taken}.
- Correct prediction: only head advances and count decrements. spec_history is unchanged (already contains the prediction).
- Simultaneous push and correct resolve: both happen; count unchanged.
- Push accepted when full is allowed if resolve pops in the same cycle: push_ready stays !full, so it is not.
- Simultaneous push and mispredicting resolve: push dropped (wrong path); history repair wins.
- resolve_valid with empty queue:
  - Ignored, no training.
  - underflow_err set and held until reset.
- Pointer wrap at DEPTH-1 -> 0, handled by the wrap bit. full vs empty is never ambiguous.

Optional Feature:
- Macro BP_INFLIGHT_STATS_EN.
- Defined: adds outputs stat_resolved, stat_mispred, stat_trained, each 32 bits.
  - Each is a saturating counter incremented on resolve, mispredict and train_valid respectively.
  - Cleared by rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg holds:
  - Constants HISTORY_SIZE, IDX_W, SUM_W, THETA.
  - typedef bp_meta_t {idx, sum, pred, history}, shared with the predictor and trainer.
- One natural sub-module: inflight_fifo. It provides generic circular storage with a flush input; the speculative-history and training logic stays in the parent.

Test Plan:
- Reset then push 3 branches (pred 1,0,1) from history 0 -> spec_history low bits 3'b101, count=3; entry 1 snapshot = ...01.
- Push idx=5 sum=+200 pred=1, resolve taken=1 -> next cycle train_valid=0, mispredict=0 (200 > THETA).
- Push idx=7 sum=-40 pred=0, resolve taken=0 -> train_valid=1, train_idx=7, train_taken=0 (|sum| <= 133).
- Push 4 entries, resolve head as mispredicted (pred 1, taken 0) with concurrent push -> count=0, push dropped, spec_history = {head snapshot[60:0], 0}, mispredict=1.
- Fill to DEPTH=8 -> push_ready=0, 9th push ignored. Then 8 correct resolves interleaved with pushes across wrap -> FIFO order preserved, count tracks.
- Resolve on empty -> underflow_err=1, stays set; async rst mid-queue -> all outputs 0 immediately, before the next clk edge.
